lzc_normalize: RTL and testbench

//  Consumer side of the leading-zero-count interface: takes an operand plus its LZC result
//  (zero_num, is_zero) and left-shifts the operand so its leading one lands in the MSB.
//  2-stage pipelined normalizer (coarse shift, then fine shift) with valid/ready on both sides.

---
 rtl/lzc_pkg.sv | 17 +
 rtl/lzc_norm_stage.sv | 59 +++++
 rtl/lzc_normalize.sv | 112 +++++++++++
 tb/tb_lzc_normalize.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared helpers and beat type for the LZC normalizer path.
package lzc_pkg;

  function automatic int lzc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int NORM_WIDTH = 21;
  localparam int NORM_CNT_W = lzc_cnt_w(NORM_WIDTH);

  typedef struct packed {
    logic [NORM_WIDTH-1:0] data;
    logic [NORM_CNT_W-1:0] zero_num;
    logic                  is_zero;
  } norm_beat_t;

endpackage

// File: rtl/lzc_norm_stage.sv
// One normalizer pipeline stage: shift by STEP * zero_num[FIELD_LO +: FIELD_W], valid/ready register.
module lzc_norm_stage #(
  parameter int WIDTH    = 21,
  parameter int CNT_W    = 5,
  parameter int STEP     = 1,
  parameter int FIELD_LO = 0,
  parameter int FIELD_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_zero_num,
  input  logic             in_is_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_zero_num,
  output logic             out_is_zero
);

  logic [WIDTH-1:0] shifted;
  logic             adv;

  generate
    if (FIELD_W > 0) begin : g_shift
      logic [FIELD_W-1:0] field;
      always_comb begin
        field   = in_zero_num[FIELD_LO +: FIELD_W];
        shifted = in_data << (STEP * int'(field));
      end
    end else begin : g_pass
      always_comb shifted = in_data;
    end
  endgenerate

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_zero_num <= '0;
      out_is_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data     <= shifted;
        out_zero_num <= in_zero_num;
        out_is_zero  <= in_is_zero;
      end
    end
  end

endmodule

// File: rtl/lzc_normalize.sv
// Two-stage leading-one normalizer (coarse x4 shift, then fine shift) with valid/ready.
// Optional consistency checker enabled by macro LZC_NORM_CHECK_EN.
module lzc_normalize
  import lzc_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int CNT_W = lzc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_zero_num,
  input  logic             in_is_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_is_zero,
  output logic             out_err
);

  logic             sat;
  logic [WIDTH-1:0] sat_data;
  logic [CNT_W-1:0] sat_zn;
  logic             sat_zero;

  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_data;
  logic [CNT_W-1:0] s1_zn;
  logic             s1_zero;

  // Zero or out-of-range counts collapse to a zero result with saturated shift.
  always_comb begin
    sat      = in_is_zero || (in_zero_num >= CNT_W'(WIDTH));
    sat_data = sat ? '0 : in_data;
    sat_zn   = sat ? CNT_W'(WIDTH) : in_zero_num;
    sat_zero = sat;
  end

  lzc_norm_stage #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .STEP     (4),
    .FIELD_LO (2),
    .FIELD_W  (CNT_W - 2)
  ) u_coarse (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (sat_data),
    .in_zero_num  (sat_zn),
    .in_is_zero   (sat_zero),
    .out_valid    (s1_valid),
    .out_ready    (s2_ready),
    .out_data     (s1_data),
    .out_zero_num (s1_zn),
    .out_is_zero  (s1_zero)
  );

  lzc_norm_stage #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .STEP     (1),
    .FIELD_LO (0),
    .FIELD_W  (2)
  ) u_fine (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (s1_valid),
    .in_ready     (s2_ready),
    .in_data      (s1_data),
    .in_zero_num  (s1_zn),
    .in_is_zero   (s1_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero_num (out_shift),
    .out_is_zero  (out_is_zero)
  );

`ifdef LZC_NORM_CHECK_EN
  // Saturation erases in_data, so the "is_zero but data nonzero" flag rides alongside the pipe.
  logic bad1;
  logic bad2;
  logic err_q;
  logic bad_now;

  always_comb begin
    bad_now = out_valid && ((!out_is_zero && !out_data[WIDTH-1]) || bad2);
    out_err = err_q || bad_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bad1  <= 1'b0;
      bad2  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (in_ready && in_valid) bad1 <= in_is_zero && (|in_data);
      if (s2_ready && s1_valid) bad2 <= bad1;
      if (bad_now) err_q <= 1'b1;
    end
  end
`else
  always_comb out_err = 1'b0;
`endif

endmodule

// File: tb/tb_lzc_normalize.sv
// Scoreboard bench for lzc_normalize (WIDTH=21): driver pushes expectations, monitor pops on output handshake.
module tb_lzc_normalize;
  import lzc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_data;
  logic [4:0]  in_zero_num;
  logic        in_is_zero;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_data;
  logic [4:0]  out_shift;
  logic        out_is_zero;
  logic        out_err;

  always #5 clk = ~clk;

  lzc_normalize #(.WIDTH(21)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_zero_num (in_zero_num),
    .in_is_zero  (in_is_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_shift   (out_shift),
    .out_is_zero (out_is_zero),
    .out_err     (out_err)
  );

  typedef struct {
    logic [20:0] d;
    logic [4:0]  zn;
    logic        iz;
    logic [20:0] ed;
    logic [4:0]  es;
    logic        ez;
    logic        bad;
  } vec_t;

  vec_t vecs [14] = '{
    '{21'h000001, 5'd20, 1'b0, 21'h100000, 5'd20, 1'b0, 1'b0},
    '{21'h0F0000, 5'd1,  1'b0, 21'h1E0000, 5'd1,  1'b0, 1'b0},
    '{21'h100000, 5'd0,  1'b0, 21'h100000, 5'd0,  1'b0, 1'b0},
    '{21'h000000, 5'd21, 1'b1, 21'h000000, 5'd21, 1'b1, 1'b0},
    '{21'h000003, 5'd31, 1'b0, 21'h000000, 5'd21, 1'b1, 1'b0},
    '{21'h000000, 5'd5,  1'b1, 21'h000000, 5'd21, 1'b1, 1'b0},
    '{21'h010000, 5'd4,  1'b0, 21'h100000, 5'd4,  1'b0, 1'b0},
    '{21'h003FFF, 5'd7,  1'b0, 21'h1FFF80, 5'd7,  1'b0, 1'b0},
    '{21'h0000AB, 5'd13, 1'b0, 21'h156000, 5'd13, 1'b0, 1'b0},
    '{21'h1FFFFF, 5'd0,  1'b0, 21'h1FFFFF, 5'd0,  1'b0, 1'b0},
    '{21'h000002, 5'd19, 1'b0, 21'h100000, 5'd19, 1'b0, 1'b0},
    '{21'h000001, 5'd3,  1'b0, 21'h000008, 5'd3,  1'b0, 1'b1},
    '{21'h000C00, 5'd9,  1'b0, 21'h180000, 5'd9,  1'b0, 1'b0},
    '{21'h040000, 5'd2,  1'b0, 21'h100000, 5'd2,  1'b0, 1'b0}
  };

  norm_beat_t sb_q[$];
  logic       err_q[$];
  logic       sticky;
  int         n_cmp;
  int         n_err;
  int         accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h shift %0d with empty scoreboard", out_data, out_shift);
      end else begin
        norm_beat_t e;
        logic       ee;
        e  = sb_q.pop_front();
        ee = err_q.pop_front();
        n_cmp++;
        if (out_data !== e.data || out_shift !== e.zero_num || out_is_zero !== e.is_zero || out_err !== ee) begin
          n_err++;
          $display("FAIL beat: got data %h shift %0d zero %b err %b expected data %h shift %0d zero %b err %b",
                   out_data, out_shift, out_is_zero, out_err, e.data, e.zero_num, e.is_zero, ee);
        end
      end
    end
  end

  task automatic send(input int idx);
    int guard;
    in_valid    = 1'b1;
    in_data     = vecs[idx].d;
    in_zero_num = vecs[idx].zn;
    in_is_zero  = vecs[idx].iz;
    guard       = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        norm_beat_t e;
        e.data     = vecs[idx].ed;
        e.zero_num = vecs[idx].es;
        e.is_zero  = vecs[idx].ez;
`ifdef LZC_NORM_CHECK_EN
        sticky = sticky | vecs[idx].bad;
`endif
        sb_q.push_back(e);
        err_q.push_back(sticky);
        accepted++;
        @(posedge clk); #1;
        break;
      end
      guard++;
      if (guard > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: vector %0d never accepted", idx);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; accepted = 0; sticky = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_zero_num = '0; in_is_zero = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_is_zero", 32'(out_is_zero), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) send(i);
    in_valid = 1'b0;
    drain();

    // Stall: five back-to-back beats with the sink blocked for four cycles.
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 6; i < 11; i++) send(i);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_accepted", 32'(accepted), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_total", 32'(accepted), 32'd5);

    send(11);
    send(12);
    in_valid = 1'b0;
    drain();

    // Fill the pipe, then reset it with beats in flight.
    out_ready = 1'b0;
    send(13);
    send(0);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    err_q.delete();
    sticky = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_shift", 32'(out_shift), 32'd0);
    check("mid_rst_out_is_zero", 32'(out_is_zero), 32'd0);
    check("mid_rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    send(1);
    send(8);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
